// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
// Holds the FSM state enum, the nibble width and the index-width helper.
package nsa_pkg;

  localparam int NIB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_e;

  // Index must address W/NIB nibbles but never collapse to zero bits.
  function automatic int idx_width(input int w);
    int n;
    n = w / NIB;
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_add4.sv
// 4-bit combinational ripple-carry slice shared by every nibble step.
module nibble_add4
  import nsa_pkg::*;
(
  input  logic           cin,
  input  logic [NIB-1:0] x,
  input  logic [NIB-1:0] y,
  output logic           cout,
  output logic [NIB-1:0] s
);

  logic [NIB:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < NIB; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    cout = c[NIB];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// W-bit add sequenced one nibble per clock through a single nibble_add4 slice.
// Optional subtract support (sub port, b' = ~b, carry-in forced to 1) under NSA_SUB_EN.
module nibble_serial_adder_ctrl
  import nsa_pkg::*;
#(
  parameter int W = 16
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef NSA_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  // state | meaning
  // IDLE  | waiting for start; outputs hold the last result
  // RUN   | one nibble per clock, LSB nibble first
  // DONE  | done pulse, unconditional return to IDLE

  localparam int N  = W / NIB;
  localparam int IW = idx_width(W);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic sub_w;
`ifdef NSA_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  nsa_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  bp_q, bp_d;
  logic          c_q, c_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [NIB-1:0] slice_x, slice_y, slice_s;
  logic           slice_co;

  always_comb begin
    slice_x = '0;
    slice_y = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) begin
        slice_x = a_q[i*NIB +: NIB];
        slice_y = bp_q[i*NIB +: NIB];
      end
    end
  end

  nibble_add4 u_slice (
    .cin  (c_q),
    .x    (slice_x),
    .y    (slice_y),
    .cout (slice_co),
    .s    (slice_s)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    bp_d    = bp_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          a_d     = a;
          // Subtraction folds into the operand capture: b' = ~b, carry-in 1.
          bp_d    = sub_w ? ~b : b;
          c_d     = sub_w ? 1'b1 : cin;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IW'(i)) sum_d[i*NIB +: NIB] = slice_s;
        end
        c_d = slice_co;
        if (idx_q == LAST) begin
          cout_d  = slice_co;
          ovf_d   = (a_q[W-1] == bp_q[W-1]) && (slice_s[NIB-1] != a_q[W-1]);
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      bp_q    <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      bp_q    <= bp_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (W=16); subtract vectors only when NSA_SUB_EN is defined.
module tb_nibble_serial_adder_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         sub;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef NSA_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one op from a negedge; returns at the negedge after busy drops.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tcin, input logic tsub,
                        input logic [W-1:0] esum, input logic ecout, input logic eovf);
    int lat, bcnt;
    a = ta; b = tb_; cin = tcin; sub = tsub; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat  = 99;
    bcnt = busy ? 1 : 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = cyc;
        break;
      end
    end
    chk({tag, "_lat"},  lat, 4);
    chk({tag, "_sum"},  sum, esum);
    chk({tag, "_cout"}, cout, ecout);
    chk({tag, "_ovf"},  ovf, eovf);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {busy, done}, 2'b00);
    chk({tag, "_busy_cycles"}, bcnt, 5);
  endtask

  initial begin
    int t_first, t_second, dcnt;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {busy, done, sum, cout, ovf}, '0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_cin",   16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
    run_op("ovf_pos",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_neg",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
`ifdef NSA_SUB_EN
    run_op("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_eq",    16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
`endif

    // Mid-RUN start pulse with other operands must be ignored.
    a = 16'h1234; b = 16'h0FFF; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (done) begin
        dcnt++;
        chk("inject_sum", sum, 16'h2233);
      end
    end
    chk("inject_done_count", dcnt, 1);
    chk("inject_idle", busy, 1'b0);

    // Start held high: back-to-back ops every N+2 clocks.
    a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
    t_first = -1; t_second = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (done) begin
        if (t_first < 0) t_first = cyc;
        else if (t_second < 0) t_second = cyc;
        chk("b2b_sum", sum, 16'h0003);
      end
    end
    start = 1'b0;
    chk("b2b_period", t_second - t_first, 6);
    repeat (8) @(negedge clk);

    // Reset during the second RUN cycle.
    a = 16'h1234; b = 16'h0FFF; cin = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_outs", {busy, done, sum, cout, ovf}, '0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("rst_no_done", dcnt, 0);
    run_op("after_rst", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencing controller that performs a W-bit add using a single shared 4-bit ripple-carry adder slice, one nibble per clock, least-significant nibble first. The controller latches the operands, steps the slice through W/4 nibbles and carries the slice's carry-out into the next nibble through a register. It reports the result with a busy/done handshake. It sits between a requester (register file or test driver) and the 4-bit adder datapath, trading latency for area on wide adds.

## Interface
- W, 16, operand width in bits; multiple of 4, ≥4; N = W/4 nibble steps
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- a  input  W  operand A; captured on accepted start
- b  input  W  operand B; captured on accepted start
- cin  input  1  carry-in for nibble 0; captured on accepted start
- sub  input  1  subtract request (present only with NSA_SUB_EN); captured on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse: result valid
- sum  output  W  result; held from DONE until the next accepted start
- cout  output  1  carry-out of the most-significant nibble
- ovf  output  1  two's-complement signed overflow of the full W-bit operation

## Operation
- States: IDLE, RUN, DONE. Nibble index idx has width max(1, clog2(N)).
- IDLE: start=1 at a clock edge latches a, b and cin into internal registers, clears idx and the sum register, and moves to RUN. start=0 keeps the block in IDLE.
- RUN: the slice adds a[4idx+3:4idx] and b'[4idx+3:4idx] with carry c. The nibble result is written to sum[4idx+3:4idx], and c takes the slice carry-out. Nibble 0 uses the latched cin for c.
  - At idx=N-1, cout takes the slice carry-out and ovf takes (a_msb == b'_msb) && (s_msb != a_msb). The state moves to DONE.
  - Otherwise idx increments.
- DONE: done=1 for exactly one cycle. The next edge returns to IDLE unconditionally.
- start asserted in RUN or DONE is ignored, not queued.
- b' = b without subtraction.
- Outputs sum, cout and ovf change only on RUN nibble writes, and on clearing at accepted start and at reset.
- rst asserted at any time, including mid-RUN, forces IDLE, idx=0, c=0, and clears all outputs and operand registers asynchronously. The in-flight operation is discarded. There is no done pulse for the discarded operation.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0.

## Timing
- Start sampled at edge E0 → RUN from E0. Nibble k is written at edge E(k+1). DONE is entered at EN, so done is high during the cycle following EN.
- Latency from the start-sampling edge to done: N clocks (4 for W=16). Throughput: one operation per N+2 clocks.
- busy rises at E0 and falls at E(N+1).
- The slice is purely combinational, so no internal stall exists.
- sum is partially updated during RUN and is valid only from done onward.

## Configuration
- NSA_SUB_EN defined:
  - The sub port exists.
  - When the captured sub=1, b' = ~b and nibble 0 uses carry 1, ignoring cin.
  - cout is the not-borrow flag (1 means no borrow); ovf applies to a−b.
- NSA_SUB_EN undefined:
  - The sub port is absent, and the block is addition only with b' = b.

## Structure
- Shared package nsa_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - the nibble width constant NIB=4
  - a function for the index width from W
- One sub-module: nibble_add4, the 4-bit combinational ripple-carry slice with ports cin, x[3:0], y[3:0], cout, s[3:0]. It is instantiated once, and its operands are multiplexed from the latched registers by idx.

## Test plan
- W=16, a=0x1234, b=0x0FFF, cin=0, start one cycle → done 4 clocks after the start edge; sum=0x2233, cout=0, ovf=0, busy high for 5 cycles.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. The same operands with cin=1 → sum=0x0001, cout=1.
- a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1. a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- With NSA_SUB_EN: sub=1, a=0x0005, b=0x0007, cin=1 → sum=0xFFFE, cout=0, ovf=0. With sub=1, a=b=0x1234 → sum=0x0000, cout=1.
- Start held high continuously → operations complete back-to-back every 6 clocks. A start pulse injected mid-RUN with different operands does not disturb the in-flight result.
- rst pulsed during the second RUN cycle → busy, done, sum, cout and ovf read 0 immediately, there is no done pulse, and a fresh start afterward completes correctly.
